// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue controller and its watchdog.
package multdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   typedef enum logic {
      KIND_MUL = 1'b0,
      KIND_DIV = 1'b1
   } md_kind_t;

   localparam logic [4:0]  OP_RTYPE        = 5'b00000;
   localparam logic [4:0]  ALU_MUL         = 5'b00110;
   localparam logic [4:0]  ALU_DIV         = 5'b00111;
   localparam logic [4:0]  RSTATUS_REG     = 5'd30;
   localparam logic [31:0] RSTATUS_MUL_EXC = 32'd4;
   localparam logic [31:0] RSTATUS_DIV_EXC = 32'd5;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exception;
   } wb_beat_t;

   function automatic wb_beat_t data_beat(input logic [4:0] rd, input logic [31:0] data);
      return '{valid: 1'b1, rd: rd, data: data, exception: 1'b0};
   endfunction

   // Overflow, divide-by-zero and watchdog expiry all report through rstatus.
   function automatic wb_beat_t exc_beat(input md_kind_t kind);
      return '{valid:     1'b1,
               rd:        RSTATUS_REG,
               data:      (kind == KIND_DIV) ? RSTATUS_DIV_EXC : RSTATUS_MUL_EXC,
               exception: 1'b1};
   endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Saturating BUSY-cycle counter with a registered flag raised while count == TIMEOUT_CYCLES-1.
module multdiv_watchdog
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;

   assign count_nxt = (count == '1) ? count : count + CNT_W'(1);

   // The flag compares against the next count so it is high in the same cycle the count sits at LIMIT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count   <= '0;
         timeout <= 1'b0;
      end else if (clear) begin
         count   <= '0;
         timeout <= 1'b0;
      end else if (enable) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         count   <= count_nxt;
         timeout <= (count_nxt == LIMIT);
      end
   end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/stall/writeback sequencer for the shared iterative multiply/divide unit.
// Optional trivial-operand fast path enabled by defining MULTDIV_FASTPATH_EN.
module multdiv_issue_ctrl
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [4:0]  ex_opcode,
   input  logic [4:0]  ex_alu_op,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_operandA,
   input  logic [31:0] ex_operandB,
   input  logic        flush,
   input  logic        md_ready,
   input  logic        md_exception,
   input  logic [31:0] md_result,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        stall,
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception
);

   md_state_t  state;
   md_kind_t   kind_q;
   logic [4:0] rd_q;
   wb_beat_t   wb_q;

   logic is_mul;
   logic is_div;
   logic req;
   logic accept;
   logic wd_clear;
   logic wd_enable;
   logic timeout;

   assign is_mul = (ex_alu_op == ALU_MUL);
   assign is_div = (ex_alu_op == ALU_DIV);
   assign req    = ex_valid & (ex_opcode == OP_RTYPE) & (is_mul | is_div);

   // Requests are only taken in IDLE; in DONE, X still holds the completing instruction.
   assign accept = (state == ST_IDLE) & req & ~flush;

   assign stall        = accept | (state == ST_BUSY);
   assign busy         = (state != ST_IDLE);
   assign wb_valid     = wb_q.valid & ~flush;
   assign wb_rd        = wb_q.rd;
   assign wb_data      = wb_q.data;
   assign wb_exception = wb_q.exception;

`ifdef MULTDIV_FASTPATH_EN
   logic        fast_hit;
   logic [31:0] fast_data;

   // Divide by zero never matches here, so it always reaches the unit.
   always_comb begin
      fast_hit  = 1'b0;
      fast_data = '0;
      if (is_mul) begin
         fast_hit  = (ex_operandA == '0) | (ex_operandB == '0);
         fast_data = '0;
      end else if (is_div) begin
         fast_hit  = (ex_operandB == 32'd1);
         fast_data = ex_operandA;
      end
   end
`endif

   assign wd_enable = (state == ST_BUSY);
   assign wd_clear  = (state != ST_BUSY) | flush;

   multdiv_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .timeout (timeout)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         kind_q       <= KIND_MUL;
         rd_q         <= '0;
         md_operandA  <= '0;
         md_operandB  <= '0;
         md_ctrl_mult <= 1'b0;
         md_ctrl_div  <= 1'b0;
         wb_q         <= '0;
      end else begin
         // NOTE: pulse outputs default low each cycle so they can only be high for one cycle.
         md_ctrl_mult <= 1'b0;
         md_ctrl_div  <= 1'b0;
         wb_q.valid   <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept) begin
`ifdef MULTDIV_FASTPATH_EN
                  if (fast_hit) begin
                     state <= ST_DONE;
                     wb_q  <= data_beat(ex_rd, fast_data);
                  end else
`endif
                  begin
                     state        <= ST_BUSY;
                     kind_q       <= is_div ? KIND_DIV : KIND_MUL;
                     rd_q         <= ex_rd;
                     md_operandA  <= ex_operandA;
                     md_operandB  <= ex_operandB;
                     md_ctrl_mult <= is_mul;
                     md_ctrl_div  <= is_div;
                  end
               end
            end

            ST_BUSY: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else if (md_ready) begin
                  state <= ST_DONE;
                  wb_q  <= md_exception ? exc_beat(kind_q) : data_beat(rd_q, md_result);
               end else if (timeout) begin
                  state <= ST_DONE;
                  wb_q  <= exc_beat(kind_q);
               end
            end

            ST_DONE: state <= ST_IDLE;

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Table-driven bench for multdiv_issue_ctrl with a writeback scoreboard; honours MULTDIV_FASTPATH_EN.
module tb_multdiv_issue_ctrl;

   localparam int TIMEOUT = 40;
   localparam int NVEC    = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ex_valid;
   logic [4:0]  ex_opcode;
   logic [4:0]  ex_alu_op;
   logic [4:0]  ex_rd;
   logic [31:0] ex_operandA;
   logic [31:0] ex_operandB;
   logic        flush;
   logic        md_ready;
   logic        md_exception;
   logic [31:0] md_result;
   logic        md_ctrl_mult;
   logic        md_ctrl_div;
   logic [31:0] md_operandA;
   logic [31:0] md_operandB;
   logic        stall;
   logic        busy;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exception;

   typedef struct {
      string       name;
      logic        is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          lat;       // cycles from pulse to md_ready; -1 = unit never answers
      logic        unit_exc;
      logic        chain;     // next vector issues straight after DONE
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      logic        exp_exc;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exc;
   } beat_t;

   vec_t  vecs [NVEC];
   beat_t sb_q [$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clock = ~clock;

   multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(6)) dut (
      .clock        (clock),
      .reset        (reset),
      .ex_valid     (ex_valid),
      .ex_opcode    (ex_opcode),
      .ex_alu_op    (ex_alu_op),
      .ex_rd        (ex_rd),
      .ex_operandA  (ex_operandA),
      .ex_operandB  (ex_operandB),
      .flush        (flush),
      .md_ready     (md_ready),
      .md_exception (md_exception),
      .md_result    (md_result),
      .md_ctrl_mult (md_ctrl_mult),
      .md_ctrl_div  (md_ctrl_div),
      .md_operandA  (md_operandA),
      .md_operandB  (md_operandB),
      .stall        (stall),
      .busy         (busy),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_exception (wb_exception)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] unit_model(input vec_t v);
      logic [31:0] r;
      if (v.is_div) r = (v.b == 32'd0) ? 32'hFFFF_FFFF : $signed(v.a) / $signed(v.b);
      else          r = v.a * v.b;
      return r;
   endfunction

   task automatic at_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic at_sample();
      @(negedge clock);
   endtask

   task automatic drive_idle();
      ex_valid     = 1'b0;
      ex_opcode    = 5'd0;
      ex_alu_op    = 5'd0;
      ex_rd        = 5'd0;
      ex_operandA  = 32'd0;
      ex_operandB  = 32'd0;
      flush        = 1'b0;
      md_ready     = 1'b0;
      md_exception = 1'b0;
      md_result    = 32'd0;
   endtask

   task automatic drive_req(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
      ex_valid    = 1'b1;
      ex_opcode   = 5'b00000;
      ex_alu_op   = is_div ? 5'b00111 : 5'b00110;
      ex_rd       = rd;
      ex_operandA = a;
      ex_operandB = b;
   endtask

   task automatic idle_cycle();
      at_edge();
      drive_idle();
      at_sample();
      check("idle", {stall, busy, wb_valid}, 3'b000);
   endtask

   // Scoreboard: every writeback beat must match the oldest expected beat.
   always @(negedge clock) begin
      if (reset && wb_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("wb_unexpected", 32'd1, 32'd0);
         end else begin
            beat_t e;
            e = sb_q.pop_front();
            check("wb_rd", wb_rd, e.rd);
            check("wb_data", wb_data, e.data);
            check("wb_exception", wb_exception, e.exc);
         end
      end
   end

   task automatic run_txn(input vec_t v);
      int stalls;
      int limit;
      stalls = 0;
      at_edge();
      drive_req(v.is_div, v.a, v.b, v.rd);
      md_ready = 1'b0;
      sb_q.push_back('{rd: v.exp_rd, data: v.exp_data, exc: v.exp_exc});
      at_sample();
      check({v.name, ":req"}, {stall, busy}, 2'b10);
      stalls += stall;
`ifdef MULTDIV_FASTPATH_EN
      if (v.is_div ? (v.b == 32'd1) : (v.a == 32'd0 || v.b == 32'd0)) begin
         at_edge();
         at_sample();
         check({v.name, ":fast_done"}, {stall, busy, wb_valid, md_ctrl_mult, md_ctrl_div}, 5'b01100);
         check({v.name, ":stall_cycles"}, stalls, 32'd1);
      end else
`endif
      begin
         limit = (v.lat >= 0) ? v.lat + 1 : TIMEOUT;
         for (int k = 1; k <= limit; k++) begin
            at_edge();
            md_ready     = (k == v.lat + 1);
            md_exception = md_ready & v.unit_exc;
            md_result    = md_ready ? unit_model(v) : 32'd0;
            at_sample();
            stalls += stall;
            check({v.name, ":busy"}, {stall, busy, wb_valid}, 3'b110);
            if (k == 1) begin
               check({v.name, ":pulse"}, {md_ctrl_mult, md_ctrl_div}, {~v.is_div, v.is_div});
               check({v.name, ":opA"}, md_operandA, v.a);
               check({v.name, ":opB"}, md_operandB, v.b);
            end else begin
               check({v.name, ":no_pulse"}, {md_ctrl_mult, md_ctrl_div}, 2'b00);
            end
         end
         at_edge();
         md_ready     = 1'b0;
         md_exception = 1'b0;
         md_result    = 32'd0;
         at_sample();
         check({v.name, ":done"}, {stall, busy, wb_valid, md_ctrl_mult, md_ctrl_div}, 5'b01100);
         check({v.name, ":stall_cycles"}, stalls, limit + 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      //              name              div   A             B             rd    lat  uexc  chain exp_rd exp_data      exp_exc
      vecs[0] = '{"mul_7x6",        1'b0, 32'd7,        32'd6,        5'd5,  32, 1'b0, 1'b0, 5'd5,  32'd42,       1'b0};
      vecs[1] = '{"div_by_zero",    1'b1, 32'd100,      32'd0,        5'd7,  10, 1'b1, 1'b0, 5'd30, 32'd5,        1'b1};
      vecs[2] = '{"mul_3x3",        1'b0, 32'd3,        32'd3,        5'd1,   4, 1'b0, 1'b1, 5'd1,  32'd9,        1'b0};
      vecs[3] = '{"mul_m2x5",       1'b0, 32'hFFFFFFFE, 32'd5,        5'd2,   4, 1'b0, 1'b0, 5'd2,  32'hFFFFFFF6, 1'b0};
      vecs[4] = '{"mul_timeout",    1'b0, 32'd9,        32'd9,        5'd9,  -1, 1'b0, 1'b0, 5'd30, 32'd4,        1'b1};
      vecs[5] = '{"div_ready_now",  1'b1, 32'd100,      32'd7,        5'd3,   0, 1'b0, 1'b0, 5'd3,  32'd14,       1'b0};
      vecs[6] = '{"div_timeout",    1'b1, 32'd8,        32'd3,        5'd4,  -1, 1'b0, 1'b0, 5'd30, 32'd5,        1'b1};
      vecs[7] = '{"mul_overflow",   1'b0, 32'h10000,    32'h10000,    5'd6,   2, 1'b1, 1'b0, 5'd30, 32'd4,        1'b1};
      vecs[8] = '{"mul_zero",       1'b0, 32'd0,        32'd123,      5'd8,   3, 1'b0, 1'b0, 5'd8,  32'd0,        1'b0};
      vecs[9] = '{"div_by_one",     1'b1, 32'hFFFFFFF7, 32'd1,        5'd10,  5, 1'b0, 1'b0, 5'd10, 32'hFFFFFFF7, 1'b0};

      drive_idle();
      reset = 1'b0;
      #12;
      check("rst_ctrl", {md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, wb_exception}, 6'd0);
      check("rst_wb_rd", wb_rd, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_opA", md_operandA, 32'd0);
      check("rst_opB", md_operandB, 32'd0);
      at_edge();
      reset = 1'b1;
      idle_cycle();

      for (int i = 0; i < NVEC; i++) begin
         run_txn(vecs[i]);
         if (!vecs[i].chain) idle_cycle();
      end

      // Flush on BUSY cycle 5, late md_ready on cycle 6 is ignored.
      at_edge();
      drive_req(1'b0, 32'd11, 32'd13, 5'd12);
      at_sample();
      check("flush:req", {stall, busy}, 2'b10);
      for (int k = 1; k <= 7; k++) begin
         at_edge();
         flush     = (k == 5);
         md_ready  = (k == 6);
         md_result = (k == 6) ? 32'd143 : 32'd0;
         if (k >= 6) ex_valid = 1'b0;
         at_sample();
         if (k <= 5) check("flush:busy", {stall, busy, wb_valid}, 3'b110);
         else        check("flush:after", {stall, busy, wb_valid}, 3'b000);
      end
      idle_cycle();

      // Flush in IDLE blocks acceptance.
      at_edge();
      drive_req(1'b0, 32'd2, 32'd2, 5'd11);
      flush = 1'b1;
      at_sample();
      check("flush_idle:stall", {stall, busy}, 2'b00);
      idle_cycle();

      // Flush in DONE squashes the beat.
      at_edge();
      drive_req(1'b1, 32'd50, 32'd5, 5'd14);
      at_sample();
      at_edge();
      md_ready  = 1'b1;
      md_result = 32'd10;
      at_sample();
      check("flush_done:busy", {stall, busy, md_ctrl_div}, 3'b111);
      at_edge();
      md_ready = 1'b0;
      flush    = 1'b1;
      at_sample();
      check("flush_done:beat", {stall, busy, wb_valid}, 3'b010);
      idle_cycle();

      // Asynchronous reset in the middle of BUSY.
      at_edge();
      drive_req(1'b0, 32'd5, 32'd6, 5'd13);
      at_sample();
      at_edge();
      at_sample();
      at_edge();
      at_sample();
      check("rst_mid:busy", busy, 32'd1);
      at_edge();
      reset = 1'b0;
      drive_idle();
      #1;
      check("rst_mid:ctrl", {busy, stall, wb_valid, md_ctrl_mult, md_ctrl_div}, 5'd0);
      check("rst_mid:opA", md_operandA, 32'd0);
      at_edge();
      reset = 1'b1;
      at_sample();
      check("rst_mid:idle", {stall, busy, wb_valid}, 3'b000);
      idle_cycle();

      check("sb_drain", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
